gray_ptr_reader: RTL and testbench

GRAY_PTR_READER -- requirements
Module: gray_ptr_reader

---
 rtl/gray_ptr_reader.sv | 112 +++++++++++
 tb/tb_gray_ptr_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_reader.sv
// Read-side pointer logic for an asynchronous FIFO: synchronizes the remote Gray write
// pointer, tracks the local read pointer and reports fill level plus sticky error flags.
module gray_ptr_reader #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] wptr_gray_i,
    input  logic         pop_i,
    output logic         pop_ok_o,
    output logic [N-2:0] rptr_bin_o,
    output logic [N-1:0] rptr_gray_o,
    output logic [N-1:0] fill_o,
    output logic         empty_o,
    output logic [1:0]   err_o
);

    localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CAP_C = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [N-1:0] bin_to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit is set: a legal Gray step flips exactly one bit.
    function automatic logic multi_bit(input logic [N-1:0] d);
        return (d & (d - ONE_C)) != {N{1'b0}};
    endfunction

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  wsync_s;
    logic [N-1:0]                  wsync_q;
    logic [N-1:0]                  wbin_s;
    logic [N-1:0]                  rbin_q;
    logic [N-1:0]                  rbin_d;
    logic [N-1:0]                  rgray_q;
    logic [N-1:0]                  fill_s;
    logic                          empty_s;
    logic                          pop_ok_s;
    logic [1:0]                    err_q;
    logic [1:0]                    err_d;

    assign wsync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain for the remote write pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray_i};
        end
    end

    // Fill computation, pop acceptance, next read pointer and error detection.
    always_comb begin
        wbin_s   = gray_to_bin(wsync_s);
        fill_s   = wbin_s - rbin_q;
        empty_s  = (fill_s == {N{1'b0}});
        pop_ok_s = pop_i & ~empty_s;
        rbin_d   = rbin_q;
        err_d    = err_q;
        if (pop_ok_s) begin
            rbin_d = rbin_q + ONE_C;
        end else begin
            rbin_d = rbin_q;
        end
        if (multi_bit(wsync_s ^ wsync_q)) begin
            err_d[0] = 1'b1;
        end else begin
            err_d[0] = err_q[0];
        end
        // Fill beyond capacity is flagged but still reported unclamped.
        if (fill_s > CAP_C) begin
            err_d[1] = 1'b1;
        end else begin
            err_d[1] = err_q[1];
        end
    end

    // Read pointer, its Gray copy for the writer domain, previous wsync and sticky errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rbin_q  <= {N{1'b0}};
            rgray_q <= {N{1'b0}};
            wsync_q <= {N{1'b0}};
            err_q   <= 2'b00;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= bin_to_gray(rbin_d);
            wsync_q <= wsync_s;
            err_q   <= err_d;
        end
    end

    assign pop_ok_o    = pop_ok_s;
    assign rptr_bin_o  = rbin_q[N-2:0];
    assign rptr_gray_o = rgray_q;
    assign fill_o      = fill_s;
    assign empty_o     = empty_s;
    assign err_o       = err_q;

endmodule

// File: tb/tb_gray_ptr_reader.sv
// Randomized scenario bench for gray_ptr_reader (N=4, SYNC_STAGES=2) against a
// count-based reference model of the read side of an asynchronous FIFO.
module tb_gray_ptr_reader;

    localparam int N = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] wptr_gray_i = 4'b0000;
    logic       pop_i = 1'b0;
    logic       pop_ok_o;
    logic [2:0] rptr_bin_o;
    logic [3:0] rptr_gray_o;
    logic [3:0] fill_o;
    logic       empty_o;
    logic [1:0] err_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: read count, total pops, synced write pointer history.
    int         rcnt;
    int         m_pops;
    logic [3:0] ws_cur;
    logic [3:0] ws_prev;
    logic [1:0] m_err;
    logic [3:0] pipe[$];
    logic       e_pop_ok;
    logic       e_empty;
    logic [3:0] e_fill;
    logic [2:0] e_rbin;
    logic [3:0] e_rgray;

    logic [14:0] obs;
    assign obs = {pop_ok_o, fill_o, empty_o, rptr_bin_o, rptr_gray_o, err_o};

    gray_ptr_reader #(.N(N), .SYNC_STAGES(S)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .wptr_gray_i(wptr_gray_i),
        .pop_i      (pop_i),
        .pop_ok_o   (pop_ok_o),
        .rptr_bin_o (rptr_bin_o),
        .rptr_gray_o(rptr_gray_o),
        .fill_o     (fill_o),
        .empty_o    (empty_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // Gray decode by search over all codes rather than by bit manipulation.
    function automatic int g2b(input logic [3:0] g);
        for (int b = 0; b < 16; b++) begin
            if (4'(b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [3:0] b2g(input int b);
        logic [3:0] v;
        v = 4'(b % 16);
        return v ^ (v >> 1);
    endfunction

    function automatic int m_fill();
        return (g2b(ws_cur) - rcnt + 16) % 16;
    endfunction

    function automatic logic [14:0] exp_vec();
        return {e_pop_ok, e_fill, e_empty, e_rbin, e_rgray, m_err};
    endfunction

    task automatic refresh_exp();
        e_fill   = 4'(m_fill());
        e_empty  = (e_fill == 4'd0);
        e_pop_ok = pop_i && !e_empty;
        e_rbin   = 3'(rcnt % 8);
        e_rgray  = b2g(rcnt);
    endtask

    task automatic model_clear();
        rcnt    = 0;
        m_pops  = 0;
        ws_cur  = 4'b0000;
        ws_prev = 4'b0000;
        m_err   = 2'b00;
        pipe.delete();
        for (int i = 0; i < S - 1; i++) pipe.push_back(4'b0000);
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, settle 1ns past it.
    task automatic cycle(input logic [3:0] wg, input logic pop);
        bit accept;
        bit step;
        bit over;
        wptr_gray_i = wg;
        pop_i       = pop;
        accept = pop && (m_fill() != 0);
        step   = $countones(ws_cur ^ ws_prev) > 1;
        over   = m_fill() > 8;
        @(posedge clk);
        if (accept) begin
            rcnt = (rcnt + 1) % 16;
            m_pops++;
        end
        if (step) m_err[0] = 1'b1;
        if (over) m_err[1] = 1'b1;
        pipe.push_back(wg);
        ws_prev = ws_cur;
        ws_cur  = pipe.pop_front();
        #1;
        refresh_exp();
    endtask

    task automatic test_reset();
        #3;
        rst_ni      = 1'b0;
        wptr_gray_i = 4'b0101;
        pop_i       = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (obs !== {1'b0, 4'd0, 1'b1, 3'd0, 4'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_values t=%0t got=%h want=%h", $time, obs,
                     {1'b0, 4'd0, 1'b1, 3'd0, 4'd0, 2'b00});
        end
        pop_i       = 1'b0;
        wptr_gray_i = 4'b0000;
        @(negedge clk);
        rst_ni = 1'b1;
        cycle(4'b0000, 1'b0);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL after_reset got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_sync_latency();
        test_reset();
        cycle(4'b0001, 1'b0);
        vectors++;
        if (fill_o !== 4'd0 || empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_early fill=%0d empty=%b want fill=0 empty=1", fill_o, empty_o);
        end
        cycle(4'b0001, 1'b0);
        vectors++;
        if (fill_o !== 4'd1 || empty_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_arrive fill=%0d empty=%b want fill=1 empty=0", fill_o, empty_o);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL sync_model got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_pop_drain();
        test_reset();
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b0);
        vectors++;
        if (fill_o !== 4'd3) begin
            miscompares++;
            $display("FAIL drain_fill got=%0d want=3", fill_o);
        end
        for (int i = 0; i < 4; i++) begin
            pop_i = 1'b1;
            #1;
            vectors++;
            if (pop_ok_o !== (i < 3) || rptr_bin_o !== 3'(i)) begin
                miscompares++;
                $display("FAIL drain_step%0d pop_ok=%b rbin=%0d want pop_ok=%b rbin=%0d",
                         i, pop_ok_o, rptr_bin_o, (i < 3), i);
            end
            cycle(4'b0010, 1'b1);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL drain_model%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (rptr_gray_o !== 4'b0010 || empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end rgray=%b empty=%b want rgray=0010 empty=1",
                     rptr_gray_o, empty_o);
        end
        pop_i = 1'b0;
    endtask

    task automatic test_stream();
        int w;
        int budget;
        logic [3:0] max_fill;
        test_reset();
        w        = 0;
        max_fill = 4'd0;
        for (budget = 0; budget < 400 && m_pops < 20; budget++) begin
            if (w < 20 && (w - m_pops) < 8 && $urandom_range(0, 1) == 1) w++;
            cycle(b2g(w), 1'($urandom_range(0, 1)));
            if (fill_o > max_fill) max_fill = fill_o;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL stream_model cyc=%0d got=%h want=%h", budget, obs, exp_vec());
            end
        end
        vectors++;
        if (m_pops < 20) begin
            miscompares++;
            $display("FAIL stream_timeout pops=%0d want=20", m_pops);
        end
        vectors++;
        if (max_fill > 4'd8 || err_o !== 2'b00 || rptr_gray_o !== 4'b0110) begin
            miscompares++;
            $display("FAIL stream_end maxfill=%0d err=%b rgray=%b want <=8 00 0110",
                     max_fill, err_o, rptr_gray_o);
        end
        pop_i = 1'b0;
    endtask

    task automatic test_same_edge();
        test_reset();
        for (int w = 1; w <= 5; w++) cycle(b2g(w), 1'b0);
        cycle(b2g(5), 1'b0);
        for (int i = 0; i < 3; i++) cycle(b2g(5), 1'b1);
        cycle(b2g(6), 1'b0);
        vectors++;
        if (fill_o !== 4'd2 || rptr_bin_o !== 3'd3) begin
            miscompares++;
            $display("FAIL same_edge_pre fill=%0d rbin=%0d want 2 3", fill_o, rptr_bin_o);
        end
        cycle(b2g(6), 1'b1);
        vectors++;
        if (fill_o !== 4'd2 || rptr_bin_o !== 3'd4) begin
            miscompares++;
            $display("FAIL same_edge fill=%0d rbin=%0d want 2 4", fill_o, rptr_bin_o);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL same_edge_model got=%h want=%h", obs, exp_vec());
        end
        pop_i = 1'b0;
    endtask

    task automatic test_gray_error();
        test_reset();
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        vectors++;
        if (err_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL gray_err_early err=%b want bit0=0", err_o);
        end
        cycle(4'b0011, 1'b0);
        vectors++;
        if (err_o[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL gray_err_set err=%b want bit0=1", err_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0011, 1'b1);
            vectors++;
            if (obs !== exp_vec() || err_o[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL gray_err_sticky%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        test_reset();
    endtask

    task automatic test_overflow_and_reset();
        test_reset();
        for (int w = 1; w <= 9; w++) cycle(b2g(w), 1'b0);
        cycle(b2g(9), 1'b0);
        cycle(b2g(9), 1'b0);
        vectors++;
        if (fill_o !== 4'd9 || err_o !== 2'b10) begin
            miscompares++;
            $display("FAIL overflow fill=%0d err=%b want 9 10", fill_o, err_o);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL overflow_model got=%h want=%h", obs, exp_vec());
        end
        #3;
        pop_i  = 1'b1;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (obs !== {1'b0, 4'd0, 1'b1, 3'd0, 4'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL midstream_reset got=%h want=%h", obs,
                     {1'b0, 4'd0, 1'b1, 3'd0, 4'd0, 2'b00});
        end
        test_reset();
    endtask

    initial begin
        model_clear();
        refresh_exp();
        test_reset();
        test_sync_latency();
        test_pop_drain();
        test_stream();
        test_same_edge();
        test_gray_error();
        test_overflow_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
